// File: rtl/regfile_mrw.sv
// Multi-read, single-write register file with optional bypass, registered reads,
// hardwired-zero register 0 and a sequential clear engine that walks every word.
module regfile_mrw #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG0 = 1,
   parameter int BYPASS    = 1,
   parameter int REG_READ  = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
   output logic [NUM_RD*WIDTH-1:0]   rd_data,
   input  logic                      clear_req,
   output logic                      busy,
   output logic                      clear_done,
   output logic [1:0]                dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_idx;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic              w_wr_ok;
   logic              w_last;

   assign busy       = (r_state == S_CLEAR);
   assign clear_done = (r_state == S_DONE);
   assign dbg_state  = r_state;
   assign w_last     = (r_idx == ADDR_W'(DEPTH - 1));

   // Writes are blocked only while words are actually being cleared.
   assign w_wr_ok = wr_en && !busy && !((ZERO_REG0 != 0) && (wr_addr == '0));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (clear_req) w_next_state = S_CLEAR;
         S_CLEAR: if (w_last)    w_next_state = S_DONE;
         S_DONE:                 w_next_state = S_IDLE;
         default:                w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_CLEAR) r_idx <= r_idx + ADDR_W'(1);
         else                    r_idx <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr_ok) r_mem[wr_addr] <= wr_data;
         if (busy)    r_mem[r_idx]   <= '0;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [WIDTH-1:0]  w_val;

      assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

      always_comb begin
         w_val = r_mem[w_addr];
         if ((ZERO_REG0 != 0) && (w_addr == '0)) w_val = '0;
         if ((BYPASS != 0) && w_wr_ok && (w_addr == wr_addr)) w_val = wr_data;
      end

      if (REG_READ != 0) begin : g_reg
         logic [WIDTH-1:0] r_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) r_q <= '0;
            else       r_q <= w_val;
         end
         assign rd_data[p*WIDTH +: WIDTH] = r_q;
      end else begin : g_comb
         assign rd_data[p*WIDTH +: WIDTH] = w_val;
      end
   end

endmodule

// File: tb/tb_regfile_mrw.sv
// Bench for regfile_mrw: three configurations driven in lockstep and compared
// against an array model whose clear timing is derived from the start edge.
module tb_regfile_mrw;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic        clear_req;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [9:0]  rd_addr_a;
   logic [11:0] rd_addr_c;
   logic [63:0] rd_a;
   logic [63:0] rd_b;
   logic [31:0] rd_c;
   logic [2:0]  busy;
   logic [2:0]  done;
   logic [1:0]  st_a;
   logic [1:0]  st_b;
   logic [1:0]  st_c;

   always #5 clk = ~clk;

   regfile_mrw u_a (
      .clk(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr_a), .rd_data(rd_a), .clear_req(clear_req),
      .busy(busy[0]), .clear_done(done[0]), .dbg_state(st_a)
   );

   regfile_mrw #(.BYPASS(0), .REG_READ(1)) u_b (
      .clk(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr_a), .rd_data(rd_b), .clear_req(clear_req),
      .busy(busy[1]), .clear_done(done[1]), .dbg_state(st_b)
   );

   regfile_mrw #(.WIDTH(8), .DEPTH(8), .NUM_RD(4), .ZERO_REG0(0)) u_c (
      .clk(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[7:0]),
      .rd_addr(rd_addr_c), .rd_data(rd_c), .clear_req(clear_req),
      .busy(busy[2]), .clear_done(done[2]), .dbg_state(st_c)
   );

   localparam int          DEP [3] = '{32, 32, 8};
   localparam bit          ZR  [3] = '{1'b1, 1'b1, 1'b0};
   localparam bit          BYP [3] = '{1'b1, 1'b0, 1'b1};
   localparam logic [31:0] MSK [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

   logic [31:0] m [3][32];
   int          s [3];   // edge count at which the clear engine started, -1 if none
   int          n;       // edges taken since time zero (model time)
   int          checks = 0;
   int          errors = 0;
   int          cnt_busy;
   int          cnt_done;

   function automatic bit m_busy(int k);
      return (s[k] >= 0) && (n >= s[k]) && (n <= s[k] + DEP[k] - 1);
   endfunction

   function automatic bit m_done(int k);
      return (s[k] >= 0) && (n == s[k] + DEP[k]);
   endfunction

   function automatic int wa(int k);
      return int'(wr_addr) % DEP[k];
   endfunction

   function automatic logic [31:0] wd(int k);
      return wr_data & MSK[k];
   endfunction

   function automatic bit m_wok(int k);
      return wr_en && !m_busy(k) && !(ZR[k] && wa(k) == 0);
   endfunction

   function automatic logic [31:0] rexp(int k, int a);
      logic [31:0] v;
      v = (ZR[k] && a == 0) ? 32'h0 : m[k][a];
      if (BYP[k] && m_wok(k) && a == wa(k)) v = wd(k);
      return v;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         s[k] = -1;
         for (int i = 0; i < 32; i++) m[k][i] = '0;
      end
   endtask

   // One clock: combinational checks before the edge, model update at the edge,
   // registered-read checks just after it.
   task automatic cycle();
      logic [31:0] eb [2];
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         check($sformatf("a_rd%0d", p), rd_a[p*32 +: 32], rexp(0, int'(rd_addr_a[p*5 +: 5])));
         eb[p] = rexp(1, int'(rd_addr_a[p*5 +: 5]));
      end
      for (int p = 0; p < 4; p++)
         check($sformatf("c_rd%0d", p), {24'h0, rd_c[p*8 +: 8]}, rexp(2, int'(rd_addr_c[p*3 +: 3])));
      for (int k = 0; k < 3; k++) begin
         check($sformatf("busy%0d", k), {31'h0, busy[k]}, {31'h0, m_busy(k)});
         check($sformatf("done%0d", k), {31'h0, done[k]}, {31'h0, m_done(k)});
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         bit bz;
         bit dn;
         bz = m_busy(k);
         dn = m_done(k);
         if (m_wok(k)) m[k][wa(k)] = wd(k);
         if (bz) m[k][n - s[k]] = '0;
         else if (!dn && clear_req) s[k] = n + 1;
      end
      n++;
      #1;
      for (int p = 0; p < 2; p++) check($sformatf("b_rd%0d", p), rd_b[p*32 +: 32], eb[p]);
   endtask

   task automatic set_wr(bit en, int a, logic [31:0] d);
      wr_en   = en;
      wr_addr = 5'(a);
      wr_data = d;
   endtask

   task automatic set_rd(int a0, int a1);
      rd_addr_a = {5'(a1), 5'(a0)};
      rd_addr_c = {3'(a1), 3'(a0), 3'(a1), 3'(a0)};
   endtask

   task automatic reset_checks(string tag);
      for (int k = 0; k < 3; k++) begin
         check({tag, "_busy"}, {31'h0, busy[k]}, 32'h0);
         check({tag, "_done"}, {31'h0, done[k]}, 32'h0);
      end
      check({tag, "_b0"}, rd_b[31:0], 32'h0);
      check({tag, "_b1"}, rd_b[63:32], 32'h0);
      for (int a = 0; a < 32; a++) begin
         set_rd(a, 31 - a);
         #1;
         check({tag, "_a0"}, rd_a[31:0], 32'h0);
         check({tag, "_a1"}, rd_a[63:32], 32'h0);
         check({tag, "_c"}, rd_c, 32'h0);
      end
   endtask

   initial begin
      rst = 1'b1;
      set_wr(1'b0, 0, 32'h0);
      clear_req = 1'b0;
      set_rd(0, 0);
      model_reset();
      n = 0;
      #1;
      check("rst_busy", {29'h0, busy}, 32'h0);
      check("rst_done", {29'h0, done}, 32'h0);
      check("rst_b", rd_b[31:0], 32'h0);
      #1 rst = 1'b0;

      // Plain write then read, and the register-0 write that must be dropped.
      set_wr(1'b1, 5, 32'hDEAD_BEEF);
      cycle();
      set_wr(1'b0, 0, 32'h0);
      set_rd(5, 0);
      #1;
      check("t1_a_r5", rd_a[31:0], 32'hDEAD_BEEF);
      check("t1_c_r5", {24'h0, rd_c[7:0]}, 32'hEF);
      cycle();
      set_wr(1'b1, 0, 32'h1234);
      set_rd(0, 0);
      #1;
      check("t1_a_r0_same", rd_a[31:0], 32'h0);
      check("t1_c_r0_bypass", {24'h0, rd_c[7:0]}, 32'h34);
      cycle();
      set_wr(1'b0, 0, 32'h0);
      #1;
      check("t1_a_r0", rd_a[31:0], 32'h0);
      check("t1_c_r0", {24'h0, rd_c[7:0]}, 32'h34);
      cycle();

      // Same-cycle write/read of r7: bypassed on a, pre-write value captured on b.
      set_wr(1'b1, 7, 32'hAAAA);
      cycle();
      set_wr(1'b1, 7, 32'h5555);
      set_rd(7, 7);
      #1;
      check("t2_a_bypass", rd_a[31:0], 32'h5555);
      cycle();
      check("t2_b_nobypass", rd_b[31:0], 32'hAAAA);
      set_wr(1'b0, 0, 32'h0);
      cycle();
      check("t2_b_after", rd_b[31:0], 32'h5555);

      // Registered read, both ports on the same address.
      set_wr(1'b1, 3, 32'h77);
      set_rd(1, 1);
      cycle();
      set_wr(1'b0, 0, 32'h0);
      set_rd(3, 3);
      cycle();
      check("t3_b_p0", rd_b[31:0], 32'h77);
      check("t3_b_p1", rd_b[63:32], 32'h77);

      // Narrow configuration: r0 is an ordinary register there.
      set_wr(1'b1, 0, 32'hC3);
      set_rd(0, 0);
      cycle();
      set_wr(1'b0, 0, 32'h0);
      #1;
      for (int p = 0; p < 4; p++) check("t6_c_r0", {24'h0, rd_c[p*8 +: 8]}, 32'hC3);
      cycle();

      // Fill, clear, and a write attempted after r9 was already cleared.
      for (int i = 1; i < 32; i++) begin
         set_wr(1'b1, i, 32'(i));
         cycle();
      end
      set_wr(1'b0, 0, 32'h0);
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      cnt_busy = int'(busy[0]);
      cnt_done = int'(done[0]);
      for (int i = 0; i < 39; i++) begin
         set_rd($urandom_range(0, 31), $urandom_range(0, 31));
         set_wr(i == 20, 9, 32'hFF);
         clear_req = (i == 12);
         cycle();
         cnt_busy += int'(busy[0]);
         cnt_done += int'(done[0]);
      end
      set_wr(1'b0, 0, 32'h0);
      clear_req = 1'b0;
      check("t4_busy_cycles", 32'(cnt_busy), 32'd32);
      check("t4_done_pulses", 32'(cnt_done), 32'd1);
      for (int a = 0; a < 32; a++) begin
         set_rd(a, a);
         cycle();
         check("t4_zero_a", rd_a[31:0], 32'h0);
      end

      // Asynchronous reset during a clear, then a clean clear afterwards.
      for (int i = 1; i < 32; i++) begin
         set_wr(1'b1, i, 32'hA0 + 32'(i));
         cycle();
      end
      set_wr(1'b0, 0, 32'h0);
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      repeat (10) cycle();
      #2 rst = 1'b1;
      model_reset();
      #1;
      reset_checks("t5");
      @(posedge clk);
      #1 rst = 1'b0;
      set_rd(0, 0);
      repeat (3) cycle();
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      cnt_busy = int'(busy[0]);
      cnt_done = int'(done[0]);
      for (int i = 0; i < 39; i++) begin
         cycle();
         cnt_busy += int'(busy[0]);
         cnt_done += int'(done[0]);
      end
      check("t5_busy_cycles", 32'(cnt_busy), 32'd32);
      check("t5_done_pulses", 32'(cnt_done), 32'd1);

      // Random traffic against the model.
      repeat (400) begin
         set_wr($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom);
         set_rd($urandom_range(0, 31), $urandom_range(0, 31));
         rd_addr_c[11:6] = 6'($urandom);
         if ($urandom_range(0, 2) == 0) rd_addr_a[4:0] = wr_addr;
         if ($urandom_range(0, 2) == 0) rd_addr_c[2:0] = wr_addr[2:0];
         clear_req = ($urandom_range(0, 39) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mrw.md
Name: regfile_mrw

Overview:
- Parametrised multi-read-port, single-write-port register file with a built-in sequential clear engine.
- Replaces the fixed 32x32 read-mux datapath in the CPU register-file path.
- Generalises word width, depth and read-port count.
- Adds optional write-to-read bypass, optional registered read outputs and a hardware-zero register 0.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 32, number of registers (power of 2, >=2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG0, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a read of the address written this cycle returns wr_data
REG_READ, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
rd_addr  in  NUM_RD*ADDR_W  read addresses; port p at bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*WIDTH  read data; port p at bits [p*WIDTH +: WIDTH]
clear_req  in  1  one-cycle request to zero every register
busy  out  1  clear engine active; writes blocked
clear_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (async, immediate):
  - All registers = 0.
  - FSM = IDLE, clear index = 0.
  - busy = 0, clear_done = 0.
  - rd_data registers (REG_READ=1) = 0.
- Write: on rising edge, mem[wr_addr] <= wr_data when all of the following hold:
  - wr_en = 1
  - busy = 0
  - NOT (ZERO_REG0 = 1 and wr_addr = 0)
  - Otherwise the write is silently dropped.
- Read port p, base value:
  - ZERO_REG0 = 1 and rd_addr[p] = 0 -> 0.
  - Otherwise mem[rd_addr[p]].
- Bypass: if BYPASS = 1, wr_en = 1, busy = 0, rd_addr[p] = wr_addr, and the write is not a dropped register-0 write, the base value is replaced by wr_data.
- Read latency:
  - REG_READ = 0: rd_data is combinational; value is valid in the same cycle.
  - REG_READ = 1: rd_data is captured at the rising edge and valid the following cycle.
  - With REG_READ = 1 and BYPASS = 0, the captured value is the pre-write contents.
- Multiple read ports are independent. Identical addresses on several ports are legal and return identical data.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: on clear_req = 1 -> CLEAR, index = 0, busy = 1 from the next cycle. A write presented in the same cycle as clear_req is still performed.
  - CLEAR: each cycle mem[index] <= 0 and index increments. When index = DEPTH-1 is written -> DONE. Duration is exactly DEPTH cycles.
  - DONE: clear_done = 1 and busy = 0 for one cycle -> IDLE. clear_req is ignored in DONE.
  - clear_req while busy is ignored; no restart, no queueing.
  - During CLEAR, reads return current contents, i.e. a mix of cleared and not-yet-cleared words. No bypass occurs because writes are blocked.
- Reset mid-clear: FSM returns to IDLE immediately, all registers = 0, no clear_done pulse.
- Addresses are always in range (DEPTH is a power of 2); no out-of-range handling is needed.

Test Plan:
1. Defaults; write 0xDEADBEEF to r5; next cycle rd_addr0 = 5 -> rd_data0 = 0xDEADBEEF. Write 0x1234 to r0, read r0 -> 0.
2. Bypass, same cycle: BYPASS = 1, r7 = 0xAAAA, write 0x5555 to r7 while reading r7 -> 0x5555 in that cycle. Repeat with BYPASS = 0 -> 0xAAAA.
3. Registered read: REG_READ = 1, read r3 (= 0x77) -> rd_data0 = 0x77 one cycle after the address; dual port reading r3 and r3 -> both 0x77.
4. Clear: fill r1..r31 with their index, pulse clear_req.
   - busy high for exactly 32 cycles, then clear_done pulses 1 cycle.
   - A write of 0xFF to r9 mid-clear is dropped; afterwards every register reads 0.
5. Reset mid-clear: assert reset asynchronously at clear cycle 10 -> busy = 0 immediately, all reads 0, no clear_done; a new clear_req afterwards completes normally.
6. Parameter sweep: WIDTH = 8, DEPTH = 8, NUM_RD = 4, ZERO_REG0 = 0.
   - Write 0xC3 to r0, read it on all 4 ports -> 0xC3.
   - Clear takes 8 cycles.
